// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] data;
  } fetch_entry_t;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // NOTE: storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests,
// buffers {pc, instr} pairs for decode and discards stale responses on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CW = cnt_w(DEPTH);
  localparam int SW = CW + 2;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CW-1:0]     r_live_cnt;
  logic [CW-1:0]     r_drop_cnt;

  logic [ADDR_W-1:0] w_inf_head;
  logic [CW-1:0]     w_inf_count;
  logic              w_inf_full;
  logic              w_inf_empty;
  logic [EW-1:0]     w_pq_head;
  logic [CW-1:0]     w_pq_count;
  logic              w_pq_full;
  logic              w_pq_empty;
  logic [SW-1:0]     w_used;
  logic              w_req_fire;
  logic              w_rsp_keep;
  logic              w_instr_fire;

  // Every issued fetch holds a queue slot until it is consumed or discarded,
  // so responses never need backpressure.
  assign w_used        = SW'(r_live_cnt) + SW'(r_drop_cnt) + SW'(w_pq_count);
  assign mem_req_valid = rst & ~redirect_valid & (w_used < SW'(DEPTH));
  assign mem_req_addr  = {r_fetch_pc[ADDR_W-1:2], 2'b00};
  assign w_req_fire    = mem_req_valid & mem_req_ready;
  assign w_rsp_keep    = mem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0);

  assign instr_valid   = rst & ~redirect_valid & ~w_pq_empty;
  assign w_instr_fire  = instr_valid & instr_ready;
  assign instr_pc      = w_pq_head[EW-1 -: ADDR_W];
  assign instr_data    = w_pq_head[DATA_W-1:0];

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_req_fire),
    .i_data  (mem_req_addr),
    .i_pop   (w_rsp_keep),
    .o_data  (w_inf_head),
    .o_count (w_inf_count),
    .o_full  (w_inf_full),
    .o_empty (w_inf_empty)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_prefetch (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_keep),
    .i_data  ({w_inf_head, mem_rsp_data}),
    .i_pop   (w_instr_fire),
    .o_data  (w_pq_head),
    .o_count (w_pq_count),
    .o_full  (w_pq_full),
    .o_empty (w_pq_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
      r_live_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still live becomes stale; a response landing now is one of them.
      r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_live_cnt <= '0;
      r_drop_cnt <= r_drop_cnt + r_live_cnt - CW'(mem_rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
      r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_rsp_keep);
      if (mem_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rsp_expected: assert (!(mem_rsp_valid && r_live_cnt == '0 && r_drop_cnt == '0));
      a_credit_cap:   assert (w_used <= SW'(DEPTH));
      a_inflight_sync: assert (w_inf_count == r_live_cnt);
      a_inf_push_ok:  assert (!(w_req_fire && w_inf_full));
      a_inf_pop_ok:   assert (!(w_rsp_keep && w_inf_empty));
      a_pq_push_ok:   assert (!(w_rsp_keep && w_pq_full && !w_instr_fire));
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute datapath.
- Owns the fetch PC and issues word requests to an instruction memory with variable latency over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions, each with its PC, in a small prefetch queue that feeds decode over a valid/ready handshake.
- On a branch/jump redirect from the core it flushes the queue and discards stale in-flight responses.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
DEPTH, 4, prefetch queue depth; also the cap on (in-flight + buffered) fetches; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset; only clock and reset in the block
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word-aligned fetch address, bits[1:0]=0
mem_rsp_valid  in  1  one instruction returned, in request order
mem_rsp_data  in  DATA_W  returned instruction
redirect_valid  in  1  core requests PC change (branch taken/jump/jr)
redirect_pc  in  ADDR_W  new fetch target; bits[1:0] ignored
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode consumes instruction
instr_data  out  DATA_W  instruction word
instr_pc  out  ADDR_W  address of instr_data

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC; queues empty; live_cnt=0; drop_cnt=0.
  - mem_req_valid=0 and instr_valid=0 while rst=0.
  - Reset mid-transaction abandons all in-flight fetches. The memory must be reset by the same rst.
- Credit rule: mem_req_valid = rst & !redirect_valid & (live_cnt + drop_cnt + q_count < DEPTH). This guarantees queue space for every response, so there is no response backpressure.
- Request handshake (valid & ready):
  - fetch_pc += 4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
  - The address is pushed into the in-flight PC queue; live_cnt increments.
- mem_req_addr = {fetch_pc[ADDR_W-1:2], 2'b00}, held stable while valid and not ready.
- Response handling:
  - If drop_cnt>0: discard the response; drop_cnt--.
  - Otherwise: pop the in-flight PC queue and push {data, pc} into the prefetch queue; live_cnt--.
- Output:
  - instr_valid = q_count>0 & !redirect_valid; instr_data/instr_pc come from the queue head.
  - The queue is registered, so a response pushed at edge t is visible at t+1. Minimum load-to-use with 1-cycle memory is request at T, response at T+1, instr_valid at T+2.
  - The head pops on instr_valid & instr_ready.
- Redirect (redirect_valid=1 at edge T):
  - fetch_pc = {redirect_pc[ADDR_W-1:2],2'b00}.
  - Prefetch queue and in-flight PC queue are flushed.
  - drop_cnt = drop_cnt + live_cnt - (mem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is always discarded.
  - No request is issued and no instruction is consumed in cycle T. The first request for the target is in T+1.
  - Back-to-back redirects: the last one wins, and each cycle's stale responses are accounted.
- Simultaneous push and pop on the prefetch queue in the same cycle: q_count is unchanged, and a full queue remains legal.
- Invariant: live_cnt + drop_cnt + q_count <= DEPTH. drop_cnt and live_cnt never underflow. A response with live_cnt=drop_cnt=0 is a protocol error (assertion).

Decomposition:
- Shared package `fetch_pkg`:
  - INSTR_BYTES=4.
  - RESET_PC default.
  - Packed struct fetch_entry_t {pc, data}.
  - Counter width function clog2(DEPTH+1).
- One sub-module, `sync_fifo` (parameterised WIDTH, DEPTH, with synchronous flush, count, full/empty). It is instantiated twice: once for the in-flight PC queue (WIDTH=ADDR_W) and once for the prefetch queue (WIDTH=ADDR_W+DATA_W).

Test Plan:
- Reset then streaming: rst low 2 cycles, mem_req_ready=1, 1-cycle memory, instr_ready=1 → addresses 0,4,8,12… issued one per cycle. instr_pc=0 appears with instr_valid 2 cycles after the first request, then one per cycle with no gaps.
- Backpressure: instr_ready=0, DEPTH=4 → exactly 4 requests (0,4,8,12), then mem_req_valid=0. Raising instr_ready yields pcs 0,4,8,12 in order and fetching resumes at 16.
- Redirect with stale in-flight: 3-cycle memory, 2 requests outstanding (0,4), redirect to 0x100 → both responses discarded, next request addr 0x100, first instr_pc=0x100, and no instr_pc 0 or 4 ever delivered.
- Redirect coincident with response and request stall: redirect_valid, mem_rsp_valid and mem_req_ready all high at the same edge → response dropped, mem_req_valid=0 that cycle, drop_cnt correct, no assertion fires.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-operation: rst low with 2 in flight and 3 buffered → instr_valid=0 the next cycle. After release, the first request is RESET_PC and the counters return to 0.
